// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_HALF = 1'b1
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_CAP  = 3'd2,
    RMW_RD  = 3'd3,
    RMW_CAP = 3'd4,
    ST_WR   = 3'd5,
    RESP    = 3'd6
  } state_e;

  // dmem is addressed in 16-bit words, so drop the byte-lane bit.
  function automatic logic [DATA_W-1:0] wordAddr(input logic [DATA_W-1:0] byteAddr);
    return {1'b0, byteAddr[DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and dmem signals between execute stage, lsu and dmem.
interface lsu_if;

  logic                        req_valid_i;
  logic                        req_ready_o;
  logic                        req_write_i;
  logic                        req_size_i;
  logic                        req_unsigned_i;
  logic [lsu_pkg::DATA_W-1:0]  req_addr_i;
  logic [lsu_pkg::DATA_W-1:0]  req_wdata_i;

  logic                        resp_valid_o;
  logic                        resp_err_o;
  logic [lsu_pkg::DATA_W-1:0]  resp_rdata_o;

  logic [lsu_pkg::DATA_W-1:0]  dmem_addr_o;
  logic [lsu_pkg::DATA_W-1:0]  dmem_wdata_o;
  logic                        dmem_write_o;
  logic                        dmem_read_o;
  logic [lsu_pkg::DATA_W-1:0]  dmem_rdata_i;

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output resp_valid_o, resp_err_o, resp_rdata_o,
    output dmem_addr_o, dmem_wdata_o, dmem_write_o, dmem_read_o,
    input  dmem_rdata_i
  );

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  resp_valid_o, resp_err_o, resp_rdata_o,
    input  dmem_addr_o, dmem_wdata_o, dmem_write_o, dmem_read_o,
    output dmem_rdata_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane helper: load extract/extend and byte-store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_byte_sel,
  input  size_e             i_size,
  input  logic              i_unsigned,
  input  logic [7:0]        i_store_byte,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0] w_byte;

  assign w_byte = i_byte_sel ? i_word[15:8] : i_word[7:0];

  always_comb begin
    o_rdata = i_word;
    if (i_size == SZ_BYTE) begin
      if (i_unsigned) begin
        o_rdata = {8'h00, w_byte};
      end else begin
        o_rdata = {{8{w_byte[7]}}, w_byte};
      end
    end
  end

  // Only the addressed lane is replaced; the other byte keeps the value read from dmem.
  always_comb begin
    o_merged = i_word;
    if (i_byte_sel) begin
      o_merged[15:8] = i_store_byte;
    end else begin
      o_merged[7:0] = i_store_byte;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request FSM, error detection and byte-store read-modify-write to dmem.
module lsu
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = 13
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W+1)'(1) << WORD_ADDR_WIDTH;

  state_e            r_state;
  state_e            w_next;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  size_e             r_size;
  logic              r_unsigned;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_err;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;
  logic              w_ready;
  logic              w_read;
  logic              w_write;
  logic              w_resp_valid;
  logic [DATA_W-1:0] w_dmem_addr;
  logic [DATA_W-1:0] w_dmem_wdata;

  assign w_accept       = (r_state == IDLE) && bus.req_valid_i;
  assign w_misaligned   = bus.req_size_i && bus.req_addr_i[0];
  assign w_out_of_range = {2'b00, bus.req_addr_i[DATA_W-1:1]} >= ADDR_LIMIT;
  assign w_err          = w_misaligned || w_out_of_range;

  lsu_align u_align (
    .i_word       (bus.dmem_rdata_i),
    .i_byte_sel   (r_addr[0]),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_store_byte (r_wdata[7:0]),
    .o_rdata      (w_load_data),
    .o_merged     (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes and address decode purely from state so a reset can never leave a half-issued access.
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_resp_valid = 1'b0;
    w_dmem_addr  = '0;
    w_dmem_wdata = '0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid_i) begin
          if (w_err) begin
            w_next = RESP;
          end else if (!bus.req_write_i) begin
            w_next = LD_RD;
          end else if (bus.req_size_i) begin
            w_next = ST_WR;
          end else begin
            w_next = RMW_RD;
          end
        end
      end
      LD_RD: begin
        w_read      = 1'b1;
        w_dmem_addr = wordAddr(r_addr);
        w_next      = LD_CAP;
      end
      LD_CAP: begin
        w_dmem_addr = wordAddr(r_addr);
        w_next      = RESP;
      end
      RMW_RD: begin
        w_read      = 1'b1;
        w_dmem_addr = wordAddr(r_addr);
        w_next      = RMW_CAP;
      end
      RMW_CAP: begin
        w_dmem_addr = wordAddr(r_addr);
        w_next      = ST_WR;
      end
      ST_WR: begin
        w_write      = 1'b1;
        w_dmem_addr  = wordAddr(r_addr);
        w_dmem_wdata = r_wdata;
        w_next       = RESP;
      end
      RESP: begin
        w_resp_valid = 1'b1;
        w_next       = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // r_wdata doubles as the merged word for byte stores, so ST_WR always writes r_wdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else if (w_accept) begin
      r_addr     <= bus.req_addr_i;
      r_wdata    <= bus.req_wdata_i;
      r_size     <= size_e'(bus.req_size_i);
      r_unsigned <= bus.req_unsigned_i;
      r_err      <= w_err;
      r_rdata    <= '0;
    end else if (r_state == LD_CAP) begin
      r_rdata <= w_load_data;
    end else if (r_state == RMW_CAP) begin
      r_wdata <= w_merged;
    end else if (r_state == RESP) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end
  end

  assign bus.req_ready_o  = w_ready;
  assign bus.resp_valid_o = w_resp_valid;
  assign bus.resp_err_o   = r_err;
  assign bus.resp_rdata_o = r_rdata;
  assign bus.dmem_addr_o  = w_dmem_addr;
  assign bus.dmem_wdata_o = w_dmem_wdata;
  assign bus.dmem_write_o = w_write;
  assign bus.dmem_read_o  = w_read;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: dmem model with registered read plus a word-array reference model of load/store rules.
module tb_lsu;
  import lsu_pkg::*;

  localparam int WAW    = 13;
  localparam int NWORDS = 1 << WAW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  lsu_if bus();

  lsu #(.WORD_ADDR_WIDTH(WAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] dmem   [NWORDS];
  logic [15:0] refMem [NWORDS];

  int checks       = 0;
  int errors       = 0;
  int rdTotal      = 0;
  int wrTotal      = 0;
  int overlapCount = 0;
  int acceptCount  = 0;
  logic [15:0] lastRdAddr = '0;
  logic [15:0] lastWrAddr = '0;
  logic [15:0] lastWrData = '0;

  // dmem model: registered read data, zero whenever no read was strobed.
  always @(posedge clk) begin
    bus.dmem_rdata_i <= bus.dmem_read_o ? dmem[bus.dmem_addr_o[WAW-1:0]] : 16'h0000;
    if (bus.dmem_write_o) dmem[bus.dmem_addr_o[WAW-1:0]] <= bus.dmem_wdata_o;
  end

  always @(posedge clk) begin
    if (bus.dmem_read_o === 1'b1) begin
      rdTotal++;
      lastRdAddr = bus.dmem_addr_o;
    end
    if (bus.dmem_write_o === 1'b1) begin
      wrTotal++;
      lastWrAddr = bus.dmem_addr_o;
      lastWrData = bus.dmem_wdata_o;
    end
    if (bus.dmem_read_o === 1'b1 && bus.dmem_write_o === 1'b1) overlapCount++;
    if (rst_n && bus.req_valid_i === 1'b1 && bus.req_ready_o === 1'b1) acceptCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain word-array arithmetic on little-endian byte lanes.
  task automatic refModel(input bit wr, input bit sz, input bit uns, input logic [15:0] addr,
                          input logic [15:0] wd, output bit expErr, output logic [15:0] expRdata,
                          output int expLat, output int expRd, output int expWr,
                          output logic [15:0] expWord, output logic [15:0] expWData);
    int word;
    int lane;
    int byteVal;
    int oldVal;
    int newVal;
    word     = int'(addr) / 2;
    lane     = int'(addr) % 2;
    expErr   = (sz && lane == 1) || (word >= NWORDS);
    expRdata = 16'h0000;
    expRd    = 0;
    expWr    = 0;
    expWord  = 16'(word);
    expWData = 16'h0000;
    if (expErr) begin
      expLat = 1;
    end else if (!wr) begin
      expLat  = 3;
      expRd   = 1;
      oldVal  = int'(refMem[word]);
      byteVal = (oldVal >> (8 * lane)) & 255;
      if (sz) expRdata = refMem[word];
      else if (uns) expRdata = 16'(byteVal);
      else expRdata = (byteVal >= 128) ? 16'(byteVal + 65280) : 16'(byteVal);
    end else if (sz) begin
      expLat       = 2;
      expWr        = 1;
      expWData     = wd;
      refMem[word] = wd;
    end else begin
      expLat = 4;
      expRd  = 1;
      expWr  = 1;
      oldVal = int'(refMem[word]);
      if (lane == 1) newVal = (oldVal & 255) + ((int'(wd) & 255) * 256);
      else newVal = (oldVal & 65280) + (int'(wd) & 255);
      expWData     = 16'(newVal);
      refMem[word] = 16'(newVal);
    end
  endtask

  // Issues one request starting at a negedge; returns at a negedge.
  task automatic applyStimulus(input bit wr, input bit sz, input bit uns, input logic [15:0] addr,
                               input logic [15:0] wd, input bit holdValid);
    bit          expErr;
    logic [15:0] expRdata;
    logic [15:0] expWord;
    logic [15:0] expWData;
    int          expLat, expRd, expWr;
    int          rd0, wr0, wait0, lat;
    refModel(wr, sz, uns, addr, wd, expErr, expRdata, expLat, expRd, expWr, expWord, expWData);
    bus.req_valid_i    = 1'b1;
    bus.req_write_i    = wr;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    wait0 = 0;
    while (bus.req_ready_o !== 1'b1 && wait0 < 50) begin
      @(negedge clk);
      wait0++;
    end
    checkOutput("acceptWait", 32'(wait0 < 50), 32'd1);
    rd0 = rdTotal;
    wr0 = wrTotal;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (!holdValid) bus.req_valid_i = 1'b0;
    while (bus.resp_valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("respErr", 32'(bus.resp_err_o), 32'(expErr));
    checkOutput("respRdata", 32'(bus.resp_rdata_o), 32'(expRdata));
    checkOutput("readyInResp", 32'(bus.req_ready_o), 32'd0);
    checkOutput("readCount", 32'(rdTotal - rd0), 32'(expRd));
    checkOutput("writeCount", 32'(wrTotal - wr0), 32'(expWr));
    if (expRd == 1) checkOutput("readAddr", 32'(lastRdAddr), 32'(expWord));
    if (expWr == 1) begin
      checkOutput("writeAddr", 32'(lastWrAddr), 32'(expWord));
      checkOutput("writeData", 32'(lastWrData), 32'(expWData));
    end
    if (!holdValid) begin
      @(negedge clk);
      checkOutput("respPulseEnd", 32'(bus.resp_valid_o), 32'd0);
      checkOutput("readyAfterResp", 32'(bus.req_ready_o), 32'd1);
    end
  endtask

  initial begin
    int          acc0;
    int          rd0;
    int          wr0;
    logic [15:0] v;
    logic [15:0] a;
    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'b0;
    bus.req_size_i     = 1'b0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;
    for (int i = 0; i < NWORDS; i++) begin
      v         = 16'($urandom);
      dmem[i]   = v;
      refMem[i] = v;
    end
    dmem[8'h08] = 16'hBEEF;  refMem[8'h08] = 16'hBEEF;
    dmem[8'h09] = 16'h80F0;  refMem[8'h09] = 16'h80F0;
    dmem[8'h10] = 16'h1234;  refMem[8'h10] = 16'h1234;

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("rstReady", 32'(bus.req_ready_o), 32'd1);
    checkOutput("rstRespValid", 32'(bus.resp_valid_o), 32'd0);
    checkOutput("rstRespErr", 32'(bus.resp_err_o), 32'd0);
    checkOutput("rstRdata", 32'(bus.resp_rdata_o), 32'd0);
    checkOutput("rstRead", 32'(bus.dmem_read_o), 32'd0);
    checkOutput("rstWrite", 32'(bus.dmem_write_o), 32'd0);
    checkOutput("rstAddr", 32'(bus.dmem_addr_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed loads and stores");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0013, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0021, 16'h005A, 1'b0);
    checkOutput("sbWordValue", 32'(dmem[16'h0010]), 32'h5A34);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0003, 16'h7777, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3FFE, 16'h0000, 1'b0);

    $display("[TB] reset during byte-store merge");
    rd0 = rdTotal;
    wr0 = wrTotal;
    bus.req_valid_i    = 1'b1;
    bus.req_write_i    = 1'b1;
    bus.req_size_i     = 1'b0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 16'h0031;
    bus.req_wdata_i    = 16'h00A5;
    checkOutput("rmwReady", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    checkOutput("rmwReadPhase", 32'(bus.dmem_read_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidRead", 32'(bus.dmem_read_o), 32'd0);
    checkOutput("rstMidWrite", 32'(bus.dmem_write_o), 32'd0);
    checkOutput("rstMidResp", 32'(bus.resp_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstMidWriteCount", 32'(wrTotal - wr0), 32'd0);
    checkOutput("rstMidReadCount", 32'(rdTotal - rd0), 32'd1);
    checkOutput("rstMidWordKept", 32'(dmem[16'h0018]), 32'(refMem[16'h0018]));
    checkOutput("rstMidReadyAfter", 32'(bus.req_ready_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

    $display("[TB] queued requests with valid held high");
    acc0 = acceptCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'hC3D2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0099, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    checkOutput("queuedAccepts", 32'(acceptCount - acc0), 32'd4);

    $display("[TB] randomized requests");
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom));
    end
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      checkOutput("finalMem", 32'(dmem[i]), 32'(refMem[i]));
    end
    checkOutput("strobeOverlap", 32'(overlapCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
